// File: rtl/clock_set_ctrl_if.sv
// Button, live-time and load bundle between the debouncers, clock_set_ctrl and Digital_Clock.
// master = button/clock side, slave = clock_set_ctrl.
interface clock_set_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic [5:0] cur_seconds;
  logic [5:0] cur_minutes;
  logic [4:0] cur_hours;
  logic       load_en;
  logic [5:0] load_seconds;
  logic [5:0] load_minutes;
  logic [4:0] load_hours;
  logic [1:0] mode;
  logic       blink;

  modport master (
    output btn_mode, btn_inc, btn_dec, cur_seconds, cur_minutes, cur_hours,
    input  load_en, load_seconds, load_minutes, load_hours, mode, blink
  );

  modport slave (
    input  btn_mode, btn_inc, btn_dec, cur_seconds, cur_minutes, cur_hours,
    output load_en, load_seconds, load_minutes, load_hours, mode, blink
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-set controller: edits shadow hours/minutes and issues a one-cycle load into Digital_Clock.
// Define CLOCK_SET_SECONDS_EN to add a seconds edit state (SET_SEC) before the commit.
//
// state     | meaning
// ----------+----------------------------------------------------
// S_RUN     | clock free-running, waiting for btn_mode
// S_SET_HR  | editing hours (mode=1)
// S_SET_MIN | editing minutes (mode=2)
// S_SET_SEC | editing seconds (mode=3), only with CLOCK_SET_SECONDS_EN
// S_COMMIT  | one-cycle load strobe to Digital_Clock (mode=0)
module clock_set_ctrl #(
  parameter int HOURS_MAX = 24,
  parameter int TIMEOUT   = 30,
  parameter int TO_W      = 6
) (
  input  logic                   Clk_1sec,
  input  logic                   reset,
  clock_set_ctrl_if.slave        bus
);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_SET_HR  = 3'd1,
    S_SET_MIN = 3'd2,
    S_SET_SEC = 3'd3,
    S_COMMIT  = 3'd4
  } state_t;

  localparam logic [4:0]      HR_LAST  = 5'(HOURS_MAX - 1);
  localparam logic [5:0]      MS_LAST  = 6'd59;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [4:0]      edit_hours_q, edit_hours_d;
  logic [5:0]      edit_minutes_q, edit_minutes_d;
`ifdef CLOCK_SET_SECONDS_EN
  logic [5:0]      edit_seconds_q, edit_seconds_d;
`endif
  logic [TO_W-1:0] to_q, to_d;
  logic            load_en_q, load_en_d;
  logic [5:0]      load_seconds_q, load_seconds_d;
  logic [5:0]      load_minutes_q, load_minutes_d;
  logic [4:0]      load_hours_q, load_hours_d;
  logic [1:0]      mode_q, mode_d;
  logic            blink_q, blink_d;

  logic btn_any, inc_only, dec_only, in_set_q, in_set_d;

  function automatic logic is_set(input state_t s);
    return (s == S_SET_HR) || (s == S_SET_MIN) || (s == S_SET_SEC);
  endfunction

  function automatic logic [1:0] mode_of(input state_t s);
    case (s)
      S_SET_HR:  return 2'd1;
      S_SET_MIN: return 2'd2;
      S_SET_SEC: return 2'd3;
      default:   return 2'd0;
    endcase
  endfunction

  function automatic logic [5:0] step60(input logic [5:0] v, input logic up, input logic dn);
    logic [5:0] r;
    r = v;
    if (up)      r = (v == MS_LAST) ? 6'd0 : v + 6'd1;
    else if (dn) r = (v == 6'd0) ? MS_LAST : v - 6'd1;
    return r;
  endfunction

  always_ff @(posedge Clk_1sec or negedge reset) begin
    if (!reset) begin
      state_q        <= S_RUN;
      edit_hours_q   <= '0;
      edit_minutes_q <= '0;
`ifdef CLOCK_SET_SECONDS_EN
      edit_seconds_q <= '0;
`endif
      to_q           <= '0;
      load_en_q      <= 1'b0;
      load_seconds_q <= '0;
      load_minutes_q <= '0;
      load_hours_q   <= '0;
      mode_q         <= '0;
      blink_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      edit_hours_q   <= edit_hours_d;
      edit_minutes_q <= edit_minutes_d;
`ifdef CLOCK_SET_SECONDS_EN
      edit_seconds_q <= edit_seconds_d;
`endif
      to_q           <= to_d;
      load_en_q      <= load_en_d;
      load_seconds_q <= load_seconds_d;
      load_minutes_q <= load_minutes_d;
      load_hours_q   <= load_hours_d;
      mode_q         <= mode_d;
      blink_q        <= blink_d;
    end
  end

  // btn_mode wins over inc/dec; inc together with dec cancels out
  assign btn_any  = bus.btn_mode | bus.btn_inc | bus.btn_dec;
  assign inc_only = bus.btn_inc & ~bus.btn_dec & ~bus.btn_mode;
  assign dec_only = bus.btn_dec & ~bus.btn_inc & ~bus.btn_mode;
  assign in_set_q = is_set(state_q);

  always_comb begin
    state_d        = state_q;
    edit_hours_d   = edit_hours_q;
    edit_minutes_d = edit_minutes_q;
`ifdef CLOCK_SET_SECONDS_EN
    edit_seconds_d = edit_seconds_q;
`endif
    case (state_q)
      S_RUN: begin
        if (bus.btn_mode) begin
          state_d        = S_SET_HR;
          edit_hours_d   = (bus.cur_hours   > HR_LAST) ? 5'd0 : bus.cur_hours;
          edit_minutes_d = (bus.cur_minutes > MS_LAST) ? 6'd0 : bus.cur_minutes;
`ifdef CLOCK_SET_SECONDS_EN
          edit_seconds_d = (bus.cur_seconds > MS_LAST) ? 6'd0 : bus.cur_seconds;
`endif
        end
      end
      S_SET_HR: begin
        if (bus.btn_mode)  state_d = S_SET_MIN;
        else if (inc_only) edit_hours_d = (edit_hours_q == HR_LAST) ? 5'd0 : edit_hours_q + 5'd1;
        else if (dec_only) edit_hours_d = (edit_hours_q == 5'd0) ? HR_LAST : edit_hours_q - 5'd1;
      end
      S_SET_MIN: begin
        if (bus.btn_mode) begin
`ifdef CLOCK_SET_SECONDS_EN
          state_d = S_SET_SEC;
`else
          state_d = S_COMMIT;
`endif
        end else begin
          edit_minutes_d = step60(edit_minutes_q, inc_only, dec_only);
        end
      end
`ifdef CLOCK_SET_SECONDS_EN
      S_SET_SEC: begin
        if (bus.btn_mode) state_d = S_COMMIT;
        else              edit_seconds_d = step60(edit_seconds_q, inc_only, dec_only);
      end
`endif
      S_COMMIT: state_d = S_RUN;
      default:  state_d = S_RUN;
    endcase

    // idle abort discards edits without a load
    if (in_set_q && !btn_any && (to_q == TO_LAST)) state_d = S_RUN;
  end

  always_comb begin
    in_set_d = is_set(state_d);
    to_d     = '0;
    if (in_set_d && in_set_q && !btn_any && (state_d == state_q)) to_d = to_q + TO_W'(1);

    mode_d         = mode_of(state_d);
    blink_d        = in_set_d ? ~blink_q : 1'b0;
    load_en_d      = (state_d == S_COMMIT);
    load_hours_d   = load_hours_q;
    load_minutes_d = load_minutes_q;
    load_seconds_d = load_seconds_q;
    if (state_d == S_COMMIT) begin
      load_hours_d   = edit_hours_d;
      load_minutes_d = edit_minutes_d;
`ifdef CLOCK_SET_SECONDS_EN
      load_seconds_d = edit_seconds_d;
`else
      load_seconds_d = 6'd0;
`endif
    end
  end

  assign bus.load_en      = load_en_q;
  assign bus.load_seconds = load_seconds_q;
  assign bus.load_minutes = load_minutes_q;
  assign bus.load_hours   = load_hours_q;
  assign bus.mode         = mode_q;
  assign bus.blink        = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: a default instance plus a HOURS_MAX=12 instance sharing buttons.
// Seconds-edit expectations follow CLOCK_SET_SECONDS_EN when the bench is built with it.
module tb_clock_set_ctrl;

`ifdef CLOCK_SET_SECONDS_EN
  localparam bit SEC_EN = 1'b1;
`else
  localparam bit SEC_EN = 1'b0;
`endif

  logic Clk_1sec = 1'b0;
  logic reset    = 1'b0;
  int   total    = 0;
  int   bad      = 0;
  logic seen_load = 1'b0;

  clock_set_ctrl_if if1 ();
  clock_set_ctrl_if if2 ();

  assign if2.btn_mode = if1.btn_mode;
  assign if2.btn_inc  = if1.btn_inc;
  assign if2.btn_dec  = if1.btn_dec;

  clock_set_ctrl u_dut (
    .Clk_1sec (Clk_1sec),
    .reset    (reset),
    .bus      (if1)
  );

  clock_set_ctrl #(.HOURS_MAX(12)) u_dut12 (
    .Clk_1sec (Clk_1sec),
    .reset    (reset),
    .bus      (if2)
  );

  always #5 Clk_1sec = ~Clk_1sec;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk_1sec);
    #1;
    if (if1.load_en) seen_load = 1'b1;
  endtask

  task automatic press(input logic m, input logic i, input logic d);
    if1.btn_mode = m;
    if1.btn_inc  = i;
    if1.btn_dec  = d;
    tick();
    if1.btn_mode = 1'b0;
    if1.btn_inc  = 1'b0;
    if1.btn_dec  = 1'b0;
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    if1.cur_hours   = 5'(h);
    if1.cur_minutes = 6'(m);
    if1.cur_seconds = 6'(s);
  endtask

  // from SET_MIN, walk to COMMIT (through SET_SEC when present)
  task automatic to_commit();
    press(1'b1, 1'b0, 1'b0);
    if (SEC_EN) press(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if1.btn_mode = 1'b0;
    if1.btn_inc  = 1'b0;
    if1.btn_dec  = 1'b0;
    set_cur(0, 0, 0);
    if2.cur_hours   = 5'd0;
    if2.cur_minutes = 6'd0;
    if2.cur_seconds = 6'd0;

    #2;
    chk("rst_mode",    if1.mode,         0);
    chk("rst_load_en", if1.load_en,      0);
    chk("rst_blink",   if1.blink,        0);
    chk("rst_load_hr", if1.load_hours,   0);
    chk("rst_load_mn", if1.load_minutes, 0);
    chk("rst_load_sc", if1.load_seconds, 0);
    @(negedge Clk_1sec);
    reset = 1'b1;
    tick();
    chk("idle_mode", if1.mode, 0);

    // full edit 10:20:33 -> 01:59:(00 or 45)
    set_cur(10, 20, 33);
    press(1'b1, 1'b0, 1'b0);
    chk("a_mode_hr",  if1.mode,  1);
    chk("a_blink_on", if1.blink, 1);
    repeat (15) press(1'b0, 1'b1, 1'b0);
    chk("a_still_hr", if1.mode, 1);
    press(1'b1, 1'b0, 1'b0);
    chk("a_mode_min", if1.mode, 2);
    repeat (21) press(1'b0, 1'b0, 1'b1);
    chk("a_still_min", if1.mode, 2);
    press(1'b1, 1'b0, 1'b0);
    if (SEC_EN) begin
      chk("a_mode_sec", if1.mode, 3);
      repeat (12) press(1'b0, 1'b1, 1'b0);
      press(1'b1, 1'b0, 1'b0);
    end
    chk("a_load_en",  if1.load_en,      1);
    chk("a_commit_m", if1.mode,         0);
    chk("a_commit_b", if1.blink,        0);
    chk("a_load_hr",  if1.load_hours,   1);
    chk("a_load_mn",  if1.load_minutes, 59);
    chk("a_load_sc",  if1.load_seconds, SEC_EN ? 45 : 0);
    tick();
    chk("a_load_off", if1.load_en,    0);
    chk("a_run_mode", if1.mode,       0);
    chk("a_hold_hr",  if1.load_hours, 1);

    // conflicts and blink toggling
    set_cur(5, 30, 7);
    press(1'b1, 1'b0, 1'b0);
    chk("b_blink1", if1.blink, 1);
    tick();
    chk("b_blink0", if1.blink, 0);
    tick();
    chk("b_blink1b", if1.blink, 1);
    press(1'b0, 1'b1, 1'b1);
    chk("b_incdec_mode", if1.mode, 1);
    press(1'b1, 1'b1, 1'b0);
    chk("b_modeinc_mode", if1.mode, 2);
    to_commit();
    chk("b_load_en", if1.load_en,      1);
    chk("b_load_hr", if1.load_hours,   5);
    chk("b_load_mn", if1.load_minutes, 30);
    chk("b_load_sc", if1.load_seconds, SEC_EN ? 7 : 0);
    tick();

    // wraps at zero / at 59; 12-hour instance wraps 0 -> 11
    set_cur(0, 59, 59);
    if2.cur_hours = 5'd0;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    to_commit();
    chk("c_load_hr",   if1.load_hours,   23);
    chk("c_load_mn",   if1.load_minutes, 0);
    chk("c_load_sc",   if1.load_seconds, SEC_EN ? 59 : 0);
    chk("c_h12_dec",   if2.load_hours,   11);
    chk("c_h12_en",    if2.load_en,      1);
    tick();

    // out-of-range capture clamps to 0; 12-hour instance wraps 11 -> 0
    set_cur(30, 61, 62);
    if2.cur_hours = 5'd11;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    to_commit();
    chk("d_clamp_hr", if1.load_hours,   1);
    chk("d_clamp_mn", if1.load_minutes, 0);
    chk("d_clamp_sc", if1.load_seconds, 0);
    chk("d_h12_inc",  if2.load_hours,   0);
    tick();

    // idle timeout: abort on the 30th idle edge, no load
    seen_load = 1'b0;
    set_cur(7, 7, 7);
    press(1'b1, 1'b0, 1'b0);
    repeat (29) tick();
    chk("t1_mode29", if1.mode, 1);
    tick();
    chk("t1_mode30", if1.mode, 0);
    chk("t1_noload", seen_load, 0);
    chk("t1_hold_hr", if1.load_hours, 1);

    // button at idle edge 20 restarts the count: abort at edge 50
    seen_load = 1'b0;
    press(1'b1, 1'b0, 1'b0);
    repeat (19) tick();
    press(1'b0, 1'b1, 1'b0);
    repeat (10) tick();
    chk("t2_mode30", if1.mode, 1);
    repeat (19) tick();
    chk("t2_mode49", if1.mode, 1);
    tick();
    chk("t2_mode50", if1.mode, 0);
    chk("t2_noload", seen_load, 0);

    // async reset mid SET_MIN, between edges
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    chk("r_pre_mode", if1.mode, 2);
    #3;
    reset = 1'b0;
    #1;
    chk("r_mode",    if1.mode,       0);
    chk("r_load_en", if1.load_en,    0);
    chk("r_blink",   if1.blink,      0);
    chk("r_load_hr", if1.load_hours, 0);
    @(negedge Clk_1sec);
    reset = 1'b1;
    seen_load = 1'b0;
    repeat (5) tick();
    chk("r_noload", seen_load, 0);
    chk("r_mode_after", if1.mode, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
